// File: rtl/instruction_loader.sv
// Host-link program loader: unpacks a framed, XOR-checked byte stream into
// big-endian words and writes them to instruction memory from address 0.
module instruction_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [15:0] widx_q, widx_d;
    logic [7:0]  xor_q, xor_d;
    logic [31:0] word_q, word_d;
    logic [15:0] len_n;

    assign len_n = {len_hi_q, in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            bcnt_q   <= '0;
            widx_q   <= '0;
            xor_q    <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            widx_q   <= widx_d;
            xor_q    <= xor_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        bcnt_d     = bcnt_q;
        widx_d     = widx_q;
        xor_d      = xor_q;
        word_d     = word_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d = len_n;
                    if (len_n > DEPTH_W)      state_d = S_ERR;
                    else if (len_n == 16'd0)  state_d = S_CHECK;
                    else                      state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d = {word_q[23:0], in_data};
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                widx_d  = widx_q + 16'd1;
                state_d = (widx_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            S_ERR: begin
                load_error = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase

        // Every accepted start begins a fresh frame with cleared counters.
        if (state_d == S_LEN_HI && state_q != S_LEN_HI) begin
            bcnt_d = '0;
            widx_d = '0;
            xor_d  = '0;
        end
    end

    // The word index doubles as the loaded-word count: both clear on start and
    // advance at the end of each WRITE.
    assign mem_addr     = {16'd0, widx_q};
    assign mem_wdata    = word_q;
    assign words_loaded = widx_q;
endmodule
